// File: rtl/micro_uart3_pkg.sv
// ---------------------------------------------------------------------------
// micro_uart3_pkg
// Shared definitions for the micro_uart3 stream controller:
//   - FSM state encoding (plain localparam constants for legacy tools)
//   - UART register index constants
//   - default status-bit positions in the UART data-register read word
// ---------------------------------------------------------------------------
package micro_uart3_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_OFF  = 3'd0;
    localparam state_t ST_CFG  = 3'd1;
    localparam state_t ST_POLL = 3'd2;
    localparam state_t ST_SEND = 3'd3;
    localparam state_t ST_WAIT = 3'd4;

    localparam logic [1:0] DATA_REG = 2'h0;
    localparam logic [1:0] BAUD_REG = 2'h1;

    localparam int DEF_RX_VALID_BIT = 8;
    localparam int DEF_TX_BUSY_BIT  = 9;

endpackage : micro_uart3_pkg

// File: rtl/micro_uart3_stream_ctrl.sv
// ---------------------------------------------------------------------------
// micro_uart3_stream_ctrl
// Autonomous owner of the micro_uart3 CPU bus. After enable it programs the
// baud register, then polls the data register every POLL_GAP idle cycles,
// forwards one TX stream byte per poll when the transmitter is idle, and
// parks received bytes in a 1-entry holding register with valid/ready out.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   enable, cfg_load         run level / baud reprogram pulse
//   baud_div                 baud register value
//   tx_valid/tx_data/tx_ready   TX byte stream in
//   rx_valid/rx_data/rx_ready   RX byte stream out (holding register)
//   busy                     controller not in OFF
//   data_select/baud_select/cpu_read/cpu_write/cpu_wdata/cpu_rdata
//                            micro_uart3 CPU bus
// ---------------------------------------------------------------------------
module micro_uart3_stream_ctrl
    import micro_uart3_pkg::*;
#(
    parameter int POLL_GAP     = 16,
    parameter int RX_VALID_BIT = DEF_RX_VALID_BIT,
    parameter int TX_BUSY_BIT  = DEF_TX_BUSY_BIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        cfg_load,
    input  logic [15:0] baud_div,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        busy,
    output logic        data_select,
    output logic        baud_select,
    output logic        cpu_read,
    output logic        cpu_write,
    output logic [15:0] cpu_wdata,
    input  logic [15:0] cpu_rdata
);

    localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] gap_cnt;
    logic       tx_busy;
    logic       tx_busy_nxt;

    logic       cfg_wr;
    logic       poll_rd;
    logic       send_wr;
    logic       rx_hit;
    logic [1:0] reg_idx;

    // Only a few status bits of the read word are consumed.
    logic       unused_rdata;
    assign unused_rdata = ^cpu_rdata;

    // Bus cycle decodes. A read is issued only with an empty holding
    // register, because a read with RX valid pops the byte inside the UART.
    // A SEND that coincides with a reprogram request is dropped so the
    // stream byte stays with the producer; a disable does not drop it.
    assign cfg_wr  = (state == ST_CFG);
    assign poll_rd = (state == ST_POLL) && !rx_valid;
    assign send_wr = (state == ST_SEND) && tx_valid && !(enable && cfg_load);
    assign rx_hit  = poll_rd && cpu_rdata[RX_VALID_BIT];

    assign reg_idx     = cfg_wr ? BAUD_REG : DATA_REG;
    assign cpu_read    = poll_rd;
    assign cpu_write   = cfg_wr || send_wr;
    assign data_select = (poll_rd || send_wr) && (reg_idx == DATA_REG);
    assign baud_select = cfg_wr && (reg_idx == BAUD_REG);
    assign cpu_wdata   = cfg_wr  ? baud_div :
                         send_wr ? {8'h00, tx_data} : 16'h0000;
    assign tx_ready    = send_wr;
    assign busy        = (state != ST_OFF);

    // The busy flag seen by this cycle: the live status during a poll,
    // the last polled value otherwise.
    assign tx_busy_nxt = poll_rd ? cpu_rdata[TX_BUSY_BIT] : tx_busy;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_OFF;
        end else if (cfg_load) begin
            state_nxt = ST_CFG;
        end else begin
            case (state)
                ST_OFF:  state_nxt = ST_CFG;
                ST_CFG:  state_nxt = ST_POLL;
                ST_POLL: begin
                    if (poll_rd) begin
                        state_nxt = (tx_valid && !tx_busy_nxt) ? ST_SEND : ST_WAIT;
                    end
                end
                ST_SEND: state_nxt = ST_WAIT;
                ST_WAIT: state_nxt = (gap_cnt == 8'd0) ? ST_POLL : ST_WAIT;
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_OFF;
            gap_cnt <= 8'd0;
            tx_busy <= 1'b1;
        end else begin
            state   <= state_nxt;
            tx_busy <= tx_busy_nxt;
            // WAIT lasts exactly POLL_GAP cycles: load on entry, leave at 0.
            if ((state_nxt == ST_WAIT) && (state != ST_WAIT)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == ST_WAIT) && (gap_cnt != 8'd0)) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    // NOTE: the holding register's data is reset as well as its valid flag,
    // since rx_data is a visible output that must read 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else if (rx_hit) begin
            rx_valid <= 1'b1;
            rx_data  <= cpu_rdata[7:0];
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule : micro_uart3_stream_ctrl

// File: tb/tb_micro_uart3_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_micro_uart3_stream_ctrl
// Self-checking bench: directed scenarios for configuration, RX holding,
// TX forwarding, reprogram/disable aborts and asynchronous reset, followed by
// a randomized run checked against a transaction-level model of the
// controller (due cycles for baud write, polls and TX writes, plus in-order
// RX/TX byte scoreboards). A small UART model drives cpu_rdata.
// ---------------------------------------------------------------------------
module tb_micro_uart3_stream_ctrl;

    localparam int G = 16;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        cfg_load;
    logic [15:0] baud_div;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        busy;
    logic        data_select;
    logic        baud_select;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;

    // UART model state: one pending RX byte and a transmitter-busy level.
    logic        uart_has;
    logic [7:0]  uart_byte;
    logic        uart_busy;
    assign cpu_rdata = {6'h00, uart_busy, uart_has, uart_byte};

    micro_uart3_stream_ctrl #(.POLL_GAP(G)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_load(cfg_load),
        .baud_div(baud_div), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .busy(busy), .data_select(data_select),
        .baud_select(baud_select), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle samples.
    int          cyc = 0;
    logic        s_poll, s_cfg, s_txw, s_ready, s_rxv, s_busy;
    logic [7:0]  s_rxd;
    logic [15:0] s_wdata;

    // Transaction-level model of the randomized run.
    bit          model_on = 0;
    int          cfg_due, poll_due, write_due;
    bit          exp_rxv;
    logic [7:0]  rx_exp[$];
    int          tx_sent = 0;
    int          rx_got = 0;

    task automatic cycle();
        bit pop_now;
        bit send;
        @(negedge clk);
        cyc++;
        s_poll  = cpu_read && data_select;
        s_cfg   = cpu_write && baud_select;
        s_txw   = cpu_write && data_select;
        s_ready = tx_ready;
        s_rxv   = rx_valid;
        s_rxd   = rx_data;
        s_busy  = busy;
        s_wdata = cpu_wdata;
        check("one_strobe", (cpu_read && cpu_write) || (data_select && baud_select), 0);
        check("read_while_full", cpu_read && rx_valid, 0);
        check("idle_bus", !cpu_read && !cpu_write &&
              (data_select || baud_select || cpu_wdata != 16'h0), 0);
        if (model_on) begin
            check("m_cfg", s_cfg, cyc == cfg_due);
            check("m_poll", s_poll, (cyc >= poll_due) && !exp_rxv);
            check("m_txw", s_txw, cyc == write_due);
            check("m_ready", s_ready, cyc == write_due);
            check("m_rxv", s_rxv, exp_rxv);
            if (s_ready) begin
                check("m_wdata", s_wdata, {8'h00, tx_data});
                tx_sent++;
            end
            if (s_rxv && rx_ready && rx_exp.size() > 0) begin
                check("m_rxd", s_rxd, rx_exp.pop_front());
                exp_rxv = 0;
                rx_got++;
            end
            if (s_poll) begin
                send      = tx_valid && !uart_busy;
                write_due = send ? cyc + 1 : -1;
                poll_due  = cyc + 1 + G + (send ? 1 : 0);
                if (uart_has) begin
                    rx_exp.push_back(uart_byte);
                    exp_rxv = 1;
                end
            end
        end
        pop_now = s_poll && uart_has;
        @(posedge clk);
        #1;
        if (pop_now) uart_has = 1'b0;
    endtask

    // Run until a poll is seen; exp >= 0 also checks the cycle count.
    task automatic wait_poll(input string tag, input int exp, input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_poll && n < budget);
        if (exp >= 0) check(tag, n, exp);
        else          check(tag, s_poll, 1);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        cfg_load = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        uart_has = 1'b0;
        uart_busy = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] burst [5];
    int n, idx, last, n_wr;

    initial begin
        reset_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; baud_div = 16'h0035;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        uart_has = 1'b0; uart_byte = 8'h00; uart_busy = 1'b0;

        // Reset state.
        do_reset();
        check("rst_outputs", {tx_ready, rx_valid, busy, data_select, baud_select,
                              cpu_read, cpu_write}, 0);
        check("rst_wdata_rxd", {cpu_wdata, rx_data}, 0);

        // T1: baud write at +1, first poll at +2.
        cycle();
        enable = 1'b1;
        cycle();
        check("t1_off_busy", s_busy, 0);
        check("t1_off_nostrobe", s_cfg || s_poll || s_txw, 0);
        cycle();
        check("t1_cfg_write", s_cfg, 1);
        check("t1_cfg_wdata", s_wdata, 16'h0035);
        cycle();
        check("t1_first_poll", s_poll, 1);

        // T2: RX capture, stall while full, resume after drain.
        uart_has = 1'b1; uart_byte = 8'h41;
        wait_poll("t2_gap", G + 1, G + 8);
        cycle();
        check("t2_rx_valid", s_rxv, 1);
        check("t2_rx_data", s_rxd, 8'h41);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            n += int'(s_poll);
        end
        check("t2_no_poll_full", n, 0);
        check("t2_rx_hold", {s_rxv, s_rxd}, {1'b1, 8'h41});
        rx_ready = 1'b1;
        cycle();
        rx_ready = 1'b0;
        cycle();
        check("t2_poll_resume", {s_poll, s_rxv}, 2'b10);

        // T3: send when idle; defer when busy.
        tx_valid = 1'b1; tx_data = 8'hA5;
        wait_poll("t3_poll", G + 1, G + 8);
        cycle();
        check("t3_write", {s_txw, s_ready}, 2'b11);
        check("t3_wdata", s_wdata, 16'h00A5);
        tx_valid = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h5A; uart_busy = 1'b1;
        cycle();
        check("t3_send_to_wait", s_txw || s_poll, 0);
        wait_poll("t3_gap_after_send", G, G + 8);
        cycle();
        check("t3_busy_nowrite", {s_txw, s_ready}, 2'b00);
        uart_busy = 1'b0;
        wait_poll("t3_retry", G, G + 8);
        cycle();
        check("t3_retry_write", {s_ready, s_wdata}, {1'b1, 16'h005A});
        tx_valid = 1'b0;

        // T4: five-byte burst, one write per poll.
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        tx_valid = 1'b1; tx_data = burst[0];
        idx = 0; last = 0; n_wr = 0;
        for (int c = 0; c < 6 * (G + 2); c++) begin
            cycle();
            n_wr += int'(s_txw);
            if (s_ready && idx < 5) begin
                check("t4_wdata", s_wdata, {8'h00, burst[idx]});
                if (idx > 0) check("t4_spacing", cyc - last, G + 2);
                last = cyc;
                idx++;
                if (idx == 5) tx_valid = 1'b0;
                else          tx_data = burst[idx];
            end
        end
        check("t4_write_count", n_wr, 5);

        // T5: cfg_load on the SEND cycle, then disable during WAIT.
        tx_valid = 1'b1; tx_data = 8'hC3;
        wait_poll("t5_poll", -1, 2 * G + 8);
        cfg_load = 1'b1;
        cycle();
        check("t5_send_dropped", {s_txw, s_ready}, 2'b00);
        cfg_load = 1'b0;
        cycle();
        check("t5_reprogram", {s_cfg, s_wdata}, {1'b1, 16'h0035});
        cycle();
        check("t5_poll_after_cfg", s_poll, 1);
        cycle();
        check("t5_byte_sent", {s_ready, s_wdata}, {1'b1, 16'h00C3});
        tx_valid = 1'b0;
        cycle();
        cycle();
        enable = 1'b0;
        cycle();
        check("t5_busy_in_wait", s_busy, 1);
        cycle();
        check("t5_busy_off", s_busy, 0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            n += int'(s_poll || s_cfg || s_txw || s_busy);
        end
        check("t5_silent_off", n, 0);

        // T6: asynchronous reset in the middle of a SEND cycle.
        uart_has = 1'b1; uart_byte = 8'h99;
        tx_valid = 1'b1; tx_data = 8'h77; enable = 1'b1;
        cycle();
        cycle();
        cycle();
        check("t6_poll", s_poll, 1);
        #2;
        check("t6_send_active", {cpu_write, tx_ready, rx_valid}, 3'b111);
        reset_n = 1'b0;
        #1;
        check("t6_async_drop", {cpu_write, tx_ready, data_select, rx_valid, busy}, 0);
        enable = 1'b0; tx_valid = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        check("t6_after_release", {s_busy, s_rxv, s_txw, s_poll, s_cfg}, 0);

        // Randomized run against the transaction-level model.
        do_reset();
        baud_div  = 16'h1234;
        exp_rxv   = 0;
        cfg_due   = cyc + 2;
        poll_due  = cyc + 3;
        write_due = -1;
        model_on  = 1;
        enable    = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rx_ready  = ($urandom_range(0, 3) == 0);
            uart_busy = ($urandom_range(0, 2) == 0);
            if (!uart_has && $urandom_range(0, 1) == 1) begin
                uart_has  = 1'b1;
                uart_byte = 8'($urandom);
            end
            if (!tx_valid && $urandom_range(0, 2) == 0) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
            end
            cycle();
            if (s_ready) tx_valid = 1'b0;
        end
        model_on = 0;
        check("rand_tx_activity", tx_sent > 10, 1);
        check("rand_rx_activity", rx_got > 10, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_micro_uart3_stream_ctrl

// File: doc/micro_uart3_stream_ctrl.md
Name: micro_uart3_stream_ctrl

Overview:
Autonomous sequencer that owns the micro_uart3 CPU bus (data_select/baud_select/cpu_read/cpu_write). It is used in place of the APB wrapper when no CPU is present, e.g. boot loader or debug bridge.
- On enable it programs the baud register.
- It then polls the data register at a fixed interval.
- It moves TX bytes from a valid/ready stream into the UART.
- It presents received bytes on a valid/ready output with a 1-entry holding register.

Parameters:
POLL_GAP, 16, idle cycles between end of a poll/send and the next poll; legal range 1..255.
RX_VALID_BIT, 8, cpu_rdata bit that flags a received byte on a data read.
TX_BUSY_BIT, 9, cpu_rdata bit that flags transmitter busy on a data read.

Ports:
clk  in  1  system clock; also drives the UART.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  level; 1 = controller runs, 0 = controller idles and issues no bus strobes.
cfg_load  in  1  single-cycle pulse; reprograms the baud register while enabled.
baud_div  in  16  value written to the baud register.
tx_valid  in  1  TX byte offered.
tx_data  in  8  TX byte.
tx_ready  out  1  TX byte accepted this cycle.
rx_valid  out  1  holding register full.
rx_data  out  8  received byte.
rx_ready  in  1  consumer takes rx_data.
busy  out  1  state != OFF.
data_select  out  1  UART data register select.
baud_select  out  1  UART baud register select.
cpu_read  out  1  UART read strobe, single cycle.
cpu_write  out  1  UART write strobe, single cycle.
cpu_wdata  out  16  UART write data.
cpu_rdata  in  16  UART read data; valid combinationally in the cpu_read cycle.

Behaviour:
- Reset values: all outputs 0; state OFF; gap counter 0; tx_busy flag 1.
- Bus rules:
  - data_select/baud_select/cpu_read/cpu_write/cpu_wdata are registered-state decodes and are 0 outside the cycles below.
  - At most one strobe is active per cycle.
- UART data register contract:
  - A read returns the status bits plus the RX byte in [7:0].
  - A read with RX_VALID_BIT=1 pops the byte inside the UART.
  - The controller therefore reads only when the holding register is empty.
- FSM:
  - OFF: no strobes. enable=1 -> CFG.
  - CFG: one cycle with baud_select=1, cpu_write=1, cpu_wdata=baud_div -> POLL.
  - POLL, holding register full: no strobe, stay in POLL.
  - POLL, holding register empty: one cycle with data_select=1, cpu_read=1.
    - If cpu_rdata[RX_VALID_BIT]=1: rx_data<=cpu_rdata[7:0], rx_valid<=1 next cycle.
    - tx_busy flag <= cpu_rdata[TX_BUSY_BIT].
    - Next state is SEND if tx_valid=1 and cpu_rdata[TX_BUSY_BIT]=0; otherwise WAIT.
  - SEND, tx_valid still 1: data_select=1, cpu_write=1, cpu_wdata={8'h00,tx_data}, tx_ready=1 (combinational in that cycle).
  - SEND, tx_valid dropped: no strobe.
  - SEND -> WAIT in both cases. Only one byte is sent per poll.
  - WAIT: gap counter loads POLL_GAP-1 on entry and decrements; at 0 -> POLL. WAIT lasts exactly POLL_GAP cycles.
- Priority, evaluated each cycle:
  1. enable=0: next state OFF. Abort from any state; the strobe of the current cycle still completes.
  2. cfg_load=1 while enabled: next state CFG. A pending SEND is dropped without tx_ready, so the stream byte is retained.
  3. Normal transitions.
- RX output:
  - rx_valid && rx_ready clears rx_valid next cycle. rx_data holds while valid.
  - A clear and a new capture cannot coincide: a read requires an empty holding register at cycle start.
- Latency:
  - enable rise -> CFG write at +1 cycle -> first poll at +2.
  - Poll -> rx_valid at +1.
  - Poll -> TX write at +1.
- Reset mid-operation: asynchronous return to reset values; in-flight strobes deassert immediately.
- Disabled: the holding register keeps its content and can still be drained via rx_ready.

Decomposition:
- Package micro_uart3_pkg holds:
  - the state encoding (OFF, CFG, POLL, SEND, WAIT);
  - the register index constants DATA_REG=2'h0 and BAUD_REG=2'h1;
  - the default RX_VALID_BIT/TX_BUSY_BIT.
- No sub-module. The gap counter and holding register are inline.
- The top-level pairs this block with micro_uart3 directly.

Test Plan:
1. Reset, then enable=1, baud_div=16'h0035 -> cpu_write+baud_select with wdata 0035 in cycle 1; first cpu_read+data_select in cycle 2; no other strobes.
2. UART model returns 16'h0141 on a poll -> rx_valid=1, rx_data=8'h41 next cycle. Hold rx_ready=0 -> no cpu_read issued for 100 cycles. Pulse rx_ready -> poll resumes.
3. tx_valid=1, tx_data=8'hA5, poll returns bit9=0 -> cpu_write with wdata 00A5 and tx_ready=1 in the cycle after the poll. With bit9=1 -> no write, retry after POLL_GAP=16 cycles.
4. POLL_GAP=1 with a 5-byte TX burst, UART never busy -> exactly 5 writes. Writes are 3 cycles apart (POLL, SEND, WAIT); each poll is followed by one SEND.
5. cfg_load pulse on the SEND cycle -> no tx_ready; next cycle is a baud write; the byte is sent after the following poll. enable=0 during WAIT -> busy=0 next cycle and no strobes thereafter.
6. reset_n low mid-SEND -> cpu_write/tx_ready drop asynchronously; rx_valid=0 and state OFF after release.
